// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the I/D-cache AXI read-channel arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR_I = 2'd1,
    AR_D = 2'd2
  } arb_state_e;

  localparam logic       ID_ICACHE    = 1'b0;
  localparam logic       ID_DCACHE    = 1'b1;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [2:0] ISIZE_WORD   = 3'b010;

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STARVE_W = 4;

  // AR payload latched at grant and held until the arready handshake
  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ar_payload_t;

endpackage

// File: rtl/rd_outstanding_cnt.sv
// Per-requester in-flight burst counter with sticky underflow flag.
module rd_outstanding_cnt
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A burst issued and one retired in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_W'(MAX_OUTSTANDING)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between the I-cache and D-cache read ports,
// with outstanding-burst tracking and D-side anti-starvation.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err_unexp_r,
  output logic [1:0]  dbg_state
);

  arb_state_e          state_q, state_d;
  ar_payload_t         pay_q, pay_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0]    i_cnt, d_cnt;
  logic                i_err, d_err;
  logic                i_elig, d_elig, starve_hit;
  logic                grant_i, grant_d;
  logic                r_sel_d, r_last_hs;

  assign i_elig     = i_arvalid && (i_cnt < CNT_W'(MAX_OUTSTANDING));
  assign d_elig     = d_arvalid && (d_cnt < CNT_W'(MAX_OUTSTANDING));
  assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

  // D wins when I is not eligible or I has used up its consecutive-grant budget
  assign grant_d = (state_q == IDLE) && d_elig && (!i_elig || starve_hit);
  assign grant_i = (state_q == IDLE) && !grant_d && i_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = AR_D;
        end else if (grant_i) begin
          state_d = AR_I;
        end
      end
      AR_I, AR_D: begin
        if (arready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arvalid   = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    unique case (state_q)
      AR_I: begin
        arvalid   = 1'b1;
        i_arready = arready;
      end
      AR_D: begin
        arvalid   = 1'b1;
        d_arready = arready;
      end
      default: ;
    endcase
  end

  // Payload is captured only at grant, so requester-side changes during AR_x are ignored
  always_comb begin
    pay_d = pay_q;
    if (grant_d) begin
      pay_d = '{id: ID_DCACHE, addr: d_araddr, len: d_arlen, size: d_arsize};
    end else if (grant_i) begin
      pay_d = '{id: ID_ICACHE, addr: i_araddr, len: i_arlen, size: ISIZE_WORD};
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!d_arvalid || grant_d) begin
      starve_d = '0;
    end else if (grant_i && !starve_hit) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q    <= '0;
      starve_q <= '0;
    end else begin
      pay_q    <= pay_d;
      starve_q <= starve_d;
    end
  end

  assign arid    = {3'b000, pay_q.id};
  assign araddr  = pay_q.addr;
  assign arlen   = pay_q.len;
  assign arsize  = pay_q.size;
  assign arburst = ARBURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // R steering by rid[0]; the non-selected side sees an idle channel
  assign r_sel_d   = rid[0];
  assign rready    = r_sel_d ? d_rready : i_rready;
  assign r_last_hs = rvalid && rready && rlast;

  assign i_rvalid = rvalid && !r_sel_d;
  assign i_rlast  = rlast && !r_sel_d;
  assign i_rdata  = r_sel_d ? 32'h0 : rdata;
  assign d_rvalid = rvalid && r_sel_d;
  assign d_rlast  = rlast && r_sel_d;
  assign d_rdata  = r_sel_d ? rdata : 32'h0;

  rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt_i (
    .clk   (clk),
    .rst   (rst),
    .inc_i (i_arready),
    .dec_i (r_last_hs && !r_sel_d),
    .cnt_o (i_cnt),
    .err_o (i_err)
  );

  rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt_d (
    .clk   (clk),
    .rst   (rst),
    .inc_i (d_arready),
    .dec_i (r_last_hs && r_sel_d),
    .cnt_o (d_cnt),
    .err_o (d_err)
  );

  assign err_unexp_r = i_err || d_err;
  assign dbg_state   = state_q;

  logic unused_r_fields;
  assign unused_r_fields = ^{rresp, rid[3:1]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed + randomized bench for axi_rd_arbiter against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int unsigned MAXO = 2;
  localparam int unsigned SLIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, araddr, rdata, i_rdata, d_rdata;
  logic [3:0]  i_arlen, d_arlen, arid, arlen, arcache, rid;
  logic [2:0]  d_arsize, arsize, arprot;
  logic [1:0]  arburst, arlock, rresp, dbg_state;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic        arvalid, arready, rlast, rvalid, rready, err_unexp_r;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic id;
    int   beats;
  } burst_t;

  axi_rd_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid),
    .d_rready(d_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_unexp_r(err_unexp_r), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(arvalid), 32'd1);
  endtask

  // One R beat driven for a cycle with routing checked while it is on the bus
  task automatic send_beat(input logic [3:0] id, input logic last);
    rvalid = 1'b1; rid = id; rlast = last; rdata = $urandom;
    #1;
    if (id[0]) begin
      chk("beat_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("beat_d_rdata", d_rdata, rdata);
      chk("beat_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("beat_rready", 32'(rready), 32'(d_rready));
    end else begin
      chk("beat_i_rvalid", 32'(i_rvalid), 32'd1);
      chk("beat_i_rdata", i_rdata, rdata);
      chk("beat_i_rlast", 32'(i_rlast), 32'(last));
      chk("beat_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("beat_d_rdata", d_rdata, 32'd0);
      chk("beat_rready", 32'(rready), 32'(i_rready));
    end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  int        pulses, ng, ni, st;
  logic      exp_d;
  int        m_cnt [2];
  int        m_starve, exp_g, g, hs_id;
  logic      in_ar, cur_id, ireq, dreq, i_acc, d_acc, rv_hold, drain, ie, de, hs, rhs, sel, last_hs;
  logic [31:0] cur_addr;
  logic [3:0]  cur_len;
  logic [2:0]  cur_size;
  burst_t      bq[$];
  int          beat_n;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(axi_rd_arb_pkg::IDLE));
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arready", 32'({i_arready, d_arready}), 32'd0);
    chk("rst_err", 32'(err_unexp_r), 32'd0);
    chk("rst_cnts", 32'({dut.i_cnt, dut.d_cnt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // I-only burst of 8 beats
    i_araddr = 32'h1FC0_0000; i_arlen = 4'd7; i_arvalid = 1'b1; arready = 1'b1;
    i_rready = 1'b1; d_rready = 1'b0;
    #1 chk("t1_no_early_arvalid", 32'(arvalid), 32'd0);
    @(negedge clk);
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_arid", 32'(arid), 32'd0);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    chk("t1_arlen", 32'(arlen), 32'd7);
    chk("t1_arsize", 32'(arsize), 32'd2);
    chk("t1_arburst", 32'(arburst), 32'd1);
    chk("t1_fixed", 32'({arlock, arcache, arprot}), 32'd0);
    chk("t1_i_arready", 32'(i_arready), 32'd1);
    chk("t1_d_arready", 32'(d_arready), 32'd0);
    @(negedge clk);
    i_arvalid = 1'b0;
    chk("t1_arvalid_drop", 32'(arvalid), 32'd0);
    chk("t1_icnt1", 32'(dut.i_cnt), 32'd1);
    for (int b = 0; b < 8; b++) send_beat(4'h0, b == 7);
    chk("t1_icnt0", 32'(dut.i_cnt), 32'd0);

    // Outstanding limit blocks the third I request
    i_arvalid = 1'b1; i_arlen = 4'd0;
    for (int k = 0; k < 2; k++) begin
      i_araddr = 32'h2000_0000 + 32'(k * 16);
      @(negedge clk);
      wait_ar("t4_ar");
      chk("t4_addr", araddr, 32'h2000_0000 + 32'(k * 16));
      chk("t4_iready", 32'(i_arready), 32'd1);
      @(negedge clk);
    end
    i_araddr = 32'h2000_0040;
    repeat (4) begin
      @(negedge clk);
      chk("t4_blocked", 32'(arvalid), 32'd0);
    end
    send_beat(4'h0, 1'b1);
    wait_ar("t4_unblock");
    chk("t4_addr3", araddr, 32'h2000_0040);
    @(negedge clk);
    i_arvalid = 1'b0;
    chk("t4_icnt2", 32'(dut.i_cnt), 32'd2);
    send_beat(4'h0, 1'b1);
    send_beat(4'h0, 1'b1);
    chk("t4_icnt0", 32'(dut.i_cnt), 32'd0);

    // D payload held while arready stalls and d_araddr wanders
    arready = 1'b0; d_rready = 1'b1;
    d_araddr = 32'h8000_1000; d_arlen = 4'd3; d_arsize = 3'b011; d_arvalid = 1'b1;
    @(negedge clk);
    wait_ar("t3_ar");
    chk("t3_arid", 32'(arid), 32'd1);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      d_araddr = $urandom;
      #1;
      chk("t3_hold_addr", araddr, 32'h8000_1000);
      chk("t3_hold_len", 32'(arlen), 32'd3);
      chk("t3_hold_valid", 32'(arvalid), 32'd1);
      if (d_arready) pulses++;
      @(negedge clk);
    end
    arready = 1'b1;
    #1;
    if (d_arready) pulses++;
    chk("t3_size", 32'(arsize), 32'd3);
    @(negedge clk);
    d_arvalid = 1'b0;
    #1;
    if (d_arready) pulses++;
    @(negedge clk);
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_dcnt1", 32'(dut.d_cnt), 32'd1);
    for (int b = 0; b < 4; b++) send_beat(4'h1, b == 3);
    chk("t3_dcnt0", 32'(dut.d_cnt), 32'd0);

    // Continuous I traffic with D waiting: D forced after SLIM I grants
    i_arvalid = 1'b1; i_araddr = 32'h3000_0000; i_arlen = 4'd0;
    d_arvalid = 1'b1; d_araddr = 32'h8000_2000; d_arlen = 4'd0; d_arsize = 3'b001;
    ng = 0; ni = 0; st = 0;
    for (int c = 0; c < 40 && ng < int'(SLIM) + 1; c++) begin
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      if (arvalid) begin
        exp_d = (st == int'(SLIM));
        chk("t2_order", 32'(arid), 32'(exp_d));
        if (exp_d) begin
          chk("t2_dsize", 32'(arsize), 32'd1);
          chk("t2_daddr", araddr, 32'h8000_2000);
          st = 0;
          d_arvalid = 1'b0; i_arvalid = 1'b0;
        end else begin
          st++;
          if (ni > 0) begin
            rvalid = 1'b1; rid = 4'h0; rlast = 1'b1; rdata = $urandom;
          end
          ni++;
          i_araddr = i_araddr + 32'd16;
        end
        ng++;
      end
    end
    chk("t2_grants", 32'(ng), 32'(SLIM + 1));
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    chk("t2_icnt_same_cycle", 32'(dut.i_cnt), 32'd1);
    send_beat(4'h0, 1'b1);
    send_beat(4'h1, 1'b1);
    chk("t2_drained", 32'({dut.i_cnt, dut.d_cnt}), 32'd0);

    // Randomized traffic against the transaction-level model
    m_cnt[0] = 0; m_cnt[1] = 0; m_starve = 0; exp_g = -1; in_ar = 1'b0;
    ireq = 1'b0; dreq = 1'b0; i_acc = 1'b0; d_acc = 1'b0; rv_hold = 1'b0; beat_n = 0;
    cur_id = 1'b0; cur_addr = '0; cur_len = '0; cur_size = '0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      drain = (cyc >= 400);
      if (drain && !ireq && !dreq && !in_ar && exp_g < 0 && bq.size() == 0) break;
      @(negedge clk);
      if (exp_g >= 0) begin
        in_ar = 1'b1;
        exp_g = -1;
      end
      if (in_ar) begin
        chk("rnd_arvalid", 32'(arvalid), 32'd1);
        chk("rnd_arid", 32'(arid), 32'(cur_id));
        chk("rnd_araddr", araddr, cur_addr);
        chk("rnd_arlen", 32'(arlen), 32'(cur_len));
        chk("rnd_arsize", 32'(arsize), 32'(cur_size));
      end else begin
        chk("rnd_no_ar", 32'(arvalid), 32'd0);
      end
      chk("rnd_icnt", 32'(dut.i_cnt), 32'(m_cnt[0]));
      chk("rnd_dcnt", 32'(dut.d_cnt), 32'(m_cnt[1]));

      if (i_acc) ireq = 1'b0;
      if (d_acc) dreq = 1'b0;
      i_acc = 1'b0; d_acc = 1'b0;
      if (!ireq && !drain && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1; i_araddr = $urandom; i_arlen = 4'($urandom_range(0, 3));
      end
      if (!dreq && !drain && $urandom_range(0, 2) == 0) begin
        dreq = 1'b1; d_araddr = $urandom; d_arlen = 4'($urandom_range(0, 3));
        d_arsize = 3'($urandom);
      end
      i_arvalid = ireq; d_arvalid = dreq;
      arready  = ($urandom_range(0, 3) != 0);
      i_rready = ($urandom_range(0, 3) != 0);
      d_rready = ($urandom_range(0, 3) != 0);
      rresp    = 2'($urandom);
      if (!rv_hold && bq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rv_hold = 1'b1;
        rid     = {3'($urandom), bq[0].id};
        rlast   = (beat_n == bq[0].beats - 1);
        rdata   = $urandom;
      end
      rvalid = rv_hold;
      if (!rv_hold) rlast = 1'b0;
      #1;

      hs = in_ar && arready;
      hs_id = int'(cur_id);
      chk("rnd_i_arready", 32'(i_arready), 32'(hs && !cur_id));
      chk("rnd_d_arready", 32'(d_arready), 32'(hs && cur_id));
      if (hs) begin
        if (cur_id) d_acc = 1'b1; else i_acc = 1'b1;
        bq.push_back('{cur_id, int'(cur_len) + 1});
        in_ar = 1'b0;
      end

      sel = rid[0];
      chk("rnd_i_rvalid", 32'(i_rvalid), 32'(rvalid && !sel));
      chk("rnd_d_rvalid", 32'(d_rvalid), 32'(rvalid && sel));
      chk("rnd_i_rlast", 32'(i_rlast), 32'(rlast && !sel));
      chk("rnd_d_rlast", 32'(d_rlast), 32'(rlast && sel));
      chk("rnd_i_rdata", i_rdata, sel ? 32'd0 : rdata);
      chk("rnd_d_rdata", d_rdata, sel ? rdata : 32'd0);
      chk("rnd_rready", 32'(rready), 32'(sel ? d_rready : i_rready));
      rhs = rvalid && (sel ? d_rready : i_rready);
      last_hs = 1'b0;
      if (rhs) begin
        if (rlast) begin
          last_hs = 1'b1;
          void'(bq.pop_front());
          beat_n = 0;
        end else begin
          beat_n++;
        end
        rv_hold = 1'b0;
      end

      // Arbitration decision taken at the coming edge, from this cycle's view
      ie = ireq && (m_cnt[0] < int'(MAXO));
      de = dreq && (m_cnt[1] < int'(MAXO));
      g = -1;
      if (!in_ar && !hs) begin
        if (de && (!ie || m_starve == int'(SLIM))) g = 1;
        else if (ie) g = 0;
      end
      if (!dreq || g == 1) m_starve = 0;
      else if (g == 0 && m_starve < int'(SLIM)) m_starve++;
      if (g == 0) begin
        cur_id = 1'b0; cur_addr = i_araddr; cur_len = i_arlen; cur_size = 3'b010;
      end else if (g == 1) begin
        cur_id = 1'b1; cur_addr = d_araddr; cur_len = d_arlen; cur_size = d_arsize;
      end
      exp_g = g;

      if (hs) m_cnt[hs_id]++;
      if (last_hs) m_cnt[int'(sel)]--;
    end
    @(negedge clk);
    idle_inputs();
    chk("rnd_drained", 32'(bq.size()), 32'd0);
    chk("rnd_no_err", 32'(err_unexp_r), 32'd0);
    @(negedge clk);

    // Unexpected rlast on the D id
    i_rready = 1'b0; d_rready = 1'b1;
    send_beat(4'h1, 1'b1);
    chk("err_set", 32'(err_unexp_r), 32'd1);
    chk("err_dcnt0", 32'(dut.d_cnt), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err_unexp_r), 32'd1);

    // Reset in the middle of an AR_I with a D burst outstanding
    arready = 1'b1; d_arvalid = 1'b1; d_araddr = 32'h8000_3000; d_arlen = 4'd0;
    @(negedge clk);
    wait_ar("rst_d_ar");
    d_arvalid = 1'b0;
    @(negedge clk);
    chk("rst_pre_dcnt", 32'(dut.d_cnt), 32'd1);
    arready = 1'b0; i_arvalid = 1'b1; i_araddr = 32'h1FC0_0100;
    @(negedge clk);
    wait_ar("rst_i_ar");
    chk("rst_pre_state", 32'(dbg_state), 32'(axi_rd_arb_pkg::AR_I));
    rst = 1'b1; i_arvalid = 1'b0;
    @(negedge clk);
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(axi_rd_arb_pkg::IDLE));
    chk("midrst_cnts", 32'({dut.i_cnt, dut.d_cnt}), 32'd0);
    chk("midrst_err", 32'(err_unexp_r), 32'd0);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Registered, stateful arbiter that shares the single AXI read channel (AR/R) between the I-cache and D-cache read ports.
- Holds the grant and all AR payload stable from arvalid assertion until the arready handshake. Tracks outstanding bursts per requester and routes R beats by rid[0].
- Prevents D-cache starvation under continuous I-cache traffic.
- Sits between the cache read ports and the core AXI master interface; the AW/W/B channels bypass it.

Parameters:
- MAX_OUTSTANDING, 2: maximum in-flight read bursts per requester (1..7).
- STARVE_LIMIT, 4: consecutive I grants allowed while D is waiting before D is forced (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_araddr  in  32  I-cache read address
- i_arlen  in  4  I-cache burst length-1
- i_arvalid  in  1  I-cache AR request
- i_arready  out  1  I-cache AR accepted
- i_rdata  out  32  I-cache read data
- i_rlast  out  1  I-cache last beat
- i_rvalid  out  1  I-cache beat valid
- i_rready  in  1  I-cache beat accept
- d_araddr  in  32  D-cache read address
- d_arlen  in  4  D-cache burst length-1
- d_arsize  in  3  D-cache beat size
- d_arvalid  in  1  D-cache AR request
- d_arready  out  1  D-cache AR accepted
- d_rdata  out  32  D-cache read data
- d_rlast  out  1  D-cache last beat
- d_rvalid  out  1  D-cache beat valid
- d_rready  in  1  D-cache beat accept
- arid  out  4  {3'b0, granted requester}
- araddr  out  32  AXI AR address
- arlen  out  4  AXI AR length
- arsize  out  3  AXI AR size
- arburst  out  2  fixed INCR
- arlock  out  2  0
- arcache  out  4  0
- arprot  out  3  0
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rid  in  4  AXI R id
- rdata  in  32  AXI R data
- rresp  in  2  ignored
- rlast  in  1  AXI R last
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- err_unexp_r  out  1  sticky: rlast handshake with zero outstanding for that id
- dbg_state  out  2  current FSM state, for ILA

Behaviour:
- States: IDLE, AR_I, AR_D.
- Reset: state=IDLE; arvalid=0; AR payload regs=0; i_arready=d_arready=0; both outstanding counters=0; starve counter=0; err_unexp_r=0. Reset mid-burst drops arvalid and abandons tracking; the bus is reset together with this block.
- Eligibility: i_elig = i_arvalid & (i_cnt<MAX_OUTSTANDING); d_elig likewise.
- IDLE selection, evaluated each cycle:
  - d_elig & (~i_elig | starve==STARVE_LIMIT) -> latch D payload, go to AR_D.
  - else i_elig -> latch I payload (arsize=3'b010), go to AR_I.
  - else stay in IDLE.
- Starve counter: increments on each I grant while d_arvalid=1, saturating at STARVE_LIMIT; clears on any D grant or when d_arvalid=0.
- AR_x: arvalid=1 from registers; payload must not change. On arready=1, pulse x_arready=1 combinationally in that same cycle, increment x_cnt, return to IDLE.
- Latency: request seen -> arvalid high 1 cycle later; minimum 2 cycles between consecutive AR handshakes.
- Requester contract: x_arvalid and its payload are held until x_arready.
- R path is combinational, selected by rid[0] (0=I, 1=D):
  - Selected side gets rdata/rlast/rvalid; the other side gets rvalid=0, rlast=0, rdata=0.
  - rready = selected side's rready.
- Counter decrement on rvalid & rready & rlast for the matched id.
- Same-cycle AR handshake and rlast for the same requester: count unchanged.
- rlast handshake while the count is 0: count stays 0, err_unexp_r set until rst.
- Counters never exceed MAX_OUTSTANDING (guaranteed by eligibility) and never underflow.

Decomposition:
- Package axi_rd_arb_pkg:
  - state enum {IDLE, AR_I, AR_D}
  - ID_ICACHE=0, ID_DCACHE=1
  - ARBURST_INCR=2'b01
  - ISIZE_WORD=3'b010
- Sub-module rd_outstanding_cnt (inc, dec, cnt, err), instantiated once per requester.

Test Plan:
- Only I: i_araddr=0x1FC00000, arlen=7; arready high -> arvalid at cycle+1 with arid=0, i_arready pulse, i_cnt=1; 8 beats rid=0 with rlast on the 8th -> i_cnt=0.
- Simultaneous I and D, STARVE_LIMIT=4, I re-requesting continuously -> grant order I,I,I,I,D; the D AR carries arid=1 and d_arsize.
- arready held low 5 cycles in AR_D while d_araddr input changes -> araddr stays the latched 0x80001000 for all 5 cycles; d_arready pulses once.
- MAX_OUTSTANDING=2, two I ARs accepted with no R returned -> third i_arvalid gets no arvalid until one rlast with rid=0 completes.
- rlast handshake with rid=1 while d_cnt=0 -> err_unexp_r=1 and stays 1; d_cnt stays 0. Mid-AR_I rst=1 -> next cycle arvalid=0, state IDLE, all counters 0.
